// File: rtl/hcms_frame_sequencer.sv
// -----------------------------------------------------------------------------
// hcms_frame_sequencer
//
// Purpose:
//   Sequences an HCMS-style dot-matrix display through the steps below:
//     1. Holds display reset after power-up or host reset.
//     2. Sends two control words.
//     3. Refreshes the display with a frame of column bytes whenever the host
//        has written new data into the internal column buffer.
//   Bytes are handed to an external serial stage with a four-phase
//     DATA_LOAD / READY handshake.
//
// Parameters:
//   RESET_CYCLES : clocks DS_RESET stays high after reset release
//   CTRL_W1      : first control byte sent after reset
//   CTRL_W0      : second control byte sent after reset
//   NUM_BYTES    : column bytes per frame (at most 32, addressed by WR_ADDR)
//
// Ports:
//   CLK_i      in   system clock, rising edge
//   RST_N_i    in   asynchronous active-low reset
//   WR_EN      in   host write strobe, one byte per cycle
//   WR_ADDR    in   column buffer address [4:0]
//   WR_DATA    in   column byte [7:0] (bit 7 stored but unused by display)
//   READY      in   serial stage byte-done status
//   DATA_o     out  byte to serial stage [7:0]
//   DATA_LOAD  out  byte-load request to serial stage
//   CMD        out  register select: 1 = control word, 0 = dot data
//   DS_RESET   out  display reset request
//   BUSY       out  high whenever the sequencer is not idle
//   FRAME_DONE out  one-cycle pulse after the last byte of a frame
// -----------------------------------------------------------------------------
module hcms_frame_sequencer #(
    parameter int         RESET_CYCLES = 16,
    parameter logic [7:0] CTRL_W1      = 8'h81,
    parameter logic [7:0] CTRL_W0      = 8'h79,
    parameter int         NUM_BYTES    = 20
) (
    input  logic       CLK_i,
    input  logic       RST_N_i,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       READY,
    output logic [7:0] DATA_o,
    output logic       DATA_LOAD,
    output logic       CMD,
    output logic       DS_RESET,
    output logic       BUSY,
    output logic       FRAME_DONE
);

    localparam int             RCW         = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RCW-1:0] RST_LAST    = RCW'(RESET_CYCLES - 1);
    localparam logic [4:0]     LAST_IDX    = 5'(NUM_BYTES - 1);
    localparam logic [5:0]     NUM_BYTES_W = 6'(NUM_BYTES);

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_INIT_W1  = 3'd1,
        ST_INIT_W0  = 3'd2,
        ST_IDLE     = 3'd3,
        ST_FRAME    = 3'd4
    } state_e;

    state_e         state_q;
    logic [RCW-1:0] rst_cnt_q;
    logic [4:0]     index_q;
    logic           phase_b_q;
    logic           dirty_q;
    logic [7:0]     data_q;
    logic           load_q;
    logic           cmd_q;
    logic           ds_reset_q;
    logic           busy_q;
    logic           frame_done_q;
    logic [7:0]     col_q [NUM_BYTES];

    logic           wr_accept_s;
    logic           sending_s;
    logic           phase_a_ack_s;
    logic           byte_done_s;
    logic [7:0]     next_col_s;

    // Decode host write acceptance and handshake progress for the byte in flight.
    always_comb begin
        wr_accept_s   = 1'b0;
        sending_s     = 1'b0;
        phase_a_ack_s = 1'b0;
        byte_done_s   = 1'b0;
        if (WR_EN && ({1'b0, WR_ADDR} < NUM_BYTES_W)) begin
            wr_accept_s = 1'b1;
        end else begin
            wr_accept_s = 1'b0;
        end
        if ((state_q == ST_INIT_W1) || (state_q == ST_INIT_W0) || (state_q == ST_FRAME)) begin
            sending_s = 1'b1;
        end else begin
            sending_s = 1'b0;
        end
        // Phase A ends when the serial stage reports READY; phase B ends
        // (byte complete) once READY has dropped again.
        if (sending_s && !phase_b_q && READY) begin
            phase_a_ack_s = 1'b1;
        end else begin
            phase_a_ack_s = 1'b0;
        end
        if (sending_s && phase_b_q && !READY) begin
            byte_done_s = 1'b1;
        end else begin
            byte_done_s = 1'b0;
        end
    end

    // Look ahead to the next column byte; guarded so the index never leaves the buffer.
    always_comb begin
        next_col_s = 8'h00;
        if (index_q < LAST_IDX) begin
            next_col_s = col_q[index_q + 5'd1];
        end else begin
            next_col_s = 8'h00;
        end
    end

    // Column buffer: host writes land in any state; out-of-range addresses are dropped.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                col_q[i] <= 8'h00;
            end
        end else if (wr_accept_s) begin
            col_q[WR_ADDR] <= WR_DATA;
        end
    end

    // Sequencer FSM with registered handshake, reset and status outputs.
    always_ff @(posedge CLK_i or negedge RST_N_i) begin
        if (!RST_N_i) begin
            state_q      <= ST_RST_HOLD;
            rst_cnt_q    <= '0;
            index_q      <= 5'd0;
            phase_b_q    <= 1'b0;
            dirty_q      <= 1'b1;
            data_q       <= 8'h00;
            load_q       <= 1'b0;
            cmd_q        <= 1'b0;
            ds_reset_q   <= 1'b1;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            if (wr_accept_s) begin
                dirty_q <= 1'b1;
            end

            // Common phase-A exit: drop the load request and wait for READY low.
            if (phase_a_ack_s) begin
                load_q    <= 1'b0;
                phase_b_q <= 1'b1;
            end

            case (state_q)
                ST_RST_HOLD: begin
                    if (rst_cnt_q == RST_LAST) begin
                        state_q    <= ST_INIT_W1;
                        ds_reset_q <= 1'b0;
                        data_q     <= CTRL_W1;
                        cmd_q      <= 1'b1;
                        load_q     <= 1'b1;
                        phase_b_q  <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RCW'(1);
                    end
                end

                ST_INIT_W1: begin
                    if (byte_done_s) begin
                        state_q   <= ST_INIT_W0;
                        data_q    <= CTRL_W0;
                        cmd_q     <= 1'b1;
                        load_q    <= 1'b1;
                        phase_b_q <= 1'b0;
                    end
                end

                ST_INIT_W0: begin
                    if (byte_done_s) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        cmd_q     <= 1'b0;
                        phase_b_q <= 1'b0;
                    end
                end

                ST_IDLE: begin
                    // Start only once the host strobe is quiet, so a burst of
                    // back-to-back writes is shown in a single frame.
                    if (dirty_q && !WR_EN) begin
                        dirty_q   <= 1'b0;
                        index_q   <= 5'd0;
                        state_q   <= ST_FRAME;
                        busy_q    <= 1'b1;
                        data_q    <= col_q[0];
                        cmd_q     <= 1'b0;
                        load_q    <= 1'b1;
                        phase_b_q <= 1'b0;
                    end
                end

                ST_FRAME: begin
                    if (byte_done_s) begin
                        phase_b_q <= 1'b0;
                        if (index_q == LAST_IDX) begin
                            state_q      <= ST_IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            index_q      <= 5'd0;
                        end else begin
                            // Byte value is latched here, at its phase-A start.
                            index_q <= index_q + 5'd1;
                            data_q  <= next_col_s;
                            load_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= ST_RST_HOLD;
                    rst_cnt_q  <= '0;
                    index_q    <= 5'd0;
                    phase_b_q  <= 1'b0;
                    load_q     <= 1'b0;
                    ds_reset_q <= 1'b1;
                    busy_q     <= 1'b1;
                end
            endcase
        end
    end

    assign DATA_o     = data_q;
    assign DATA_LOAD  = load_q;
    assign CMD        = cmd_q;
    assign DS_RESET   = ds_reset_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_hcms_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hcms_frame_sequencer
//
// Self-checking bench: a serial-stage model answers the DATA_LOAD/READY
// handshake, a scoreboard queue holds the expected {CMD, byte} stream derived
// from a simple memory model of the column buffer, and a monitor pops and
// compares on every DATA_LOAD rise.
// -----------------------------------------------------------------------------
module tb_hcms_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       ready;
    logic [7:0] data_o;
    logic       data_load;
    logic       cmd;
    logic       ds_reset;
    logic       busy;
    logic       frame_done;

    hcms_frame_sequencer dut (
        .CLK_i      (clk),
        .RST_N_i    (rst_n),
        .WR_EN      (wr_en),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .READY      (ready),
        .DATA_o     (data_o),
        .DATA_LOAD  (data_load),
        .CMD        (cmd),
        .DS_RESET   (ds_reset),
        .BUSY       (busy),
        .FRAME_DONE (frame_done)
    );

    always #5 clk = ~clk;

    int         checks      = 0;
    int         failures    = 0;
    int         load_cnt    = 0;
    int         fd_cnt      = 0;
    int         exp_frames  = 0;
    int         ready_delay = 10;
    bit         model_dirty = 1'b0;
    logic [7:0] mem [20];
    logic [8:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_init();
        exp_q.push_back({1'b1, 8'h81});
        exp_q.push_back({1'b1, 8'h79});
    endtask

    // A frame shows the column buffer contents as they stand when it starts.
    task automatic push_frame();
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, mem[i]});
        exp_frames++;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 5'd20) begin
            mem[a] = d;
            model_dirty = 1'b1;
        end
    endtask

    task automatic flush_writes();
        if (model_dirty) push_frame();
        model_dirty = 1'b0;
    endtask

    task automatic measure_ds_reset(input string name);
        int n = 0;
        rst_n = 1'b1;
        while (ds_reset && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'd16);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        bit done = 1'b0;
        while (!done && n < 8000) begin
            @(negedge clk);
            n++;
            if (exp_q.size() == 0 && !busy && !data_load) done = 1'b1;
        end
        check({name, "_drain"}, 32'(done), 32'd1);
        repeat (20) @(negedge clk);
        check({name, "_frames"}, 32'(fd_cnt), 32'(exp_frames));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_loads(input int target);
        int n = 0;
        while (load_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach_load", 32'(load_cnt >= target), 32'd1);
    endtask

    // Serial stage model: READY rises ready_delay clocks into a load, falls once load drops.
    initial begin
        int ld_cnt = 0;
        forever begin
            @(negedge clk);
            if (data_load && !ready) begin
                ld_cnt++;
                if (ld_cnt >= ready_delay) begin
                    ready = 1'b1;
                    ld_cnt = 0;
                end
            end else if (!data_load) begin
                ready = 1'b0;
                ld_cnt = 0;
            end
        end
    end

    // Monitor: compare each loaded byte against the scoreboard and check it holds steady.
    initial begin
        bit         prev_load = 1'b0;
        bit         stab_bad  = 1'b0;
        logic [7:0] cap_data  = 8'h00;
        logic       cap_cmd   = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_load = 1'b0;
            end else begin
                if (frame_done) fd_cnt++;
                if (data_load && !prev_load) begin
                    load_cnt++;
                    cap_data = data_o;
                    cap_cmd  = cmd;
                    stab_bad = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_load", 32'(data_o), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte_data", 32'(data_o), 32'(e[7:0]));
                        check("byte_cmd", 32'(cmd), 32'(e[8]));
                    end
                end else if (data_load) begin
                    if (data_o !== cap_data || cmd !== cap_cmd) stab_bad = 1'b1;
                end else if (prev_load) begin
                    if (data_o !== cap_data || cmd !== cap_cmd) stab_bad = 1'b1;
                    check("byte_stable", 32'(stab_bad), 32'd0);
                end
                prev_load = data_load;
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lc;
        bit         seen;
        bit         stall_bad;
        logic [7:0] held;
        int         base;
        int         nw;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'h00; ready = 1'b0;
        for (int i = 0; i < 20; i++) mem[i] = 8'h00;

        // Reset values while reset is held.
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_load", 32'(data_load), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_ds_reset", 32'(ds_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);

        // Power-up: init words then one blank frame.
        push_init();
        push_frame();
        measure_ds_reset("ds_reset_powerup");
        wait_drained("powerup");

        // Host update in idle.
        host_write(5'd0, 8'h3E);
        host_write(5'd19, 8'h41);
        flush_writes();
        wait_drained("host_update");

        // Invalid addresses: nothing happens.
        lc = load_cnt;
        seen = 1'b0;
        host_write(5'd20, 8'hAA);
        host_write(5'd31, 8'h55);
        flush_writes();
        repeat (100) begin
            @(negedge clk);
            if (busy || data_load) seen = 1'b1;
        end
        check("invalid_busy", 32'(seen), 32'd0);
        check("invalid_loads", 32'(load_cnt), 32'(lc));

        // Mid-frame write during byte 5 to an already-sent address.
        base = load_cnt;
        host_write(5'd10, 8'h55);
        flush_writes();
        wait_loads(base + 6);
        host_write(5'd2, 8'h7F);
        flush_writes();
        wait_drained("midframe");

        // Handshake stall in phase A.
        base = load_cnt;
        host_write(5'd7, 8'h6B);
        flush_writes();
        wait_loads(base + 4);
        ready_delay = 500;
        held = data_o;
        stall_bad = 1'b0;
        repeat (480) begin
            @(negedge clk);
            if (!data_load || data_o !== held) stall_bad = 1'b1;
        end
        check("stall_hold", 32'(stall_bad), 32'd0);
        ready_delay = 10;
        wait_drained("stall");

        // Randomised bursts of host writes (any address, valid or not).
        for (int it = 0; it < 6; it++) begin
            nw = int'($urandom_range(1, 4));
            for (int j = 0; j < nw; j++) begin
                host_write(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
            end
            flush_writes();
            wait_drained("random");
        end

        // Reset during frame byte 10: abort, then init and blank frame again.
        base = load_cnt;
        host_write(5'd12, 8'hA5);
        flush_writes();
        wait_loads(base + 11);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_load", 32'(data_load), 32'd0);
        check("abort_ds_reset", 32'(ds_reset), 32'd1);
        check("abort_busy", 32'(busy), 32'd1);
        check("abort_data", 32'(data_o), 32'd0);
        // The aborted frame never completes, so it no longer counts.
        exp_q.delete();
        exp_frames--;
        for (int i = 0; i < 20; i++) mem[i] = 8'h00;
        model_dirty = 1'b0;
        push_init();
        push_frame();
        repeat (3) @(negedge clk);
        measure_ds_reset("ds_reset_abort");
        wait_drained("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
